// File: rtl/qam_rx_buffer.sv
// QAM receive capture buffer: records DEPTH demapped dibits after a start
// pulse, then serves registered random-access reads once the buffer is full.
module qam_rx_buffer #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    sym_in,
    input  logic          sym_valid,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   sym_count,
    output logic          overrun
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FULL
    } state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW:0]   cnt_nxt;
    logic          ovr_nxt;
    logic          wr_en;
    logic          rd_ok;

    logic [1:0]    mem [DEPTH];

    // start has priority over sym_valid in every state
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        cnt_nxt    = sym_count;
        ovr_nxt    = overrun;
        wr_en      = 1'b0;
        if (start) begin
            state_nxt  = CAPTURE;
            wr_ptr_nxt = '0;
            cnt_nxt    = '0;
            ovr_nxt    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                CAPTURE: begin
                    if (sym_valid) begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                        cnt_nxt    = sym_count + CNT_ONE;
                        if (wr_ptr == LAST_PTR) begin
                            state_nxt = FULL;
                        end
                    end
                end
                FULL: begin
                    if (sym_valid) begin
                        ovr_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // reads sample the current state, so a start alongside rd_en still reads
    assign rd_ok = rd_en && (state == FULL);
    assign busy  = (state == CAPTURE);
    assign done  = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            sym_count <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            sym_count <= cnt_nxt;
            overrun   <= ovr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= 2'b00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sym_in;
        end
    end

endmodule

// File: tb/tb_qam_rx_buffer.sv
// Randomised self-checking bench for qam_rx_buffer against a
// queue/array capture model.
module tb_qam_rx_buffer;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    sym_in;
    logic          sym_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   sym_count;
    logic          overrun;

    int checks;
    int errors;

    // model: 0 = waiting, 1 = capturing, 2 = full
    int         m_phase;
    int         m_count;
    logic       m_over;
    logic [1:0] m_rdata;
    logic       m_rvalid;
    logic [1:0] m_mem [DEPTH];

    qam_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .sym_count (sym_count),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic s, input logic v, input logic [1:0] d,
                       input logic r, input logic [AW-1:0] a);
        start     = s;
        sym_valid = v;
        sym_in    = d;
        rd_en     = r;
        rd_addr   = a;
        @(posedge clk);
        if (r && m_phase == 2) begin
            m_rdata  = m_mem[a];
            m_rvalid = 1'b1;
        end else begin
            m_rvalid = 1'b0;
        end
        if (s) begin
            m_phase = 1;
            m_count = 0;
            m_over  = 1'b0;
        end else if (v && m_phase == 1) begin
            m_mem[m_count] = d;
            m_count++;
            if (m_count == DEPTH) m_phase = 2;
        end else if (v && m_phase == 2) begin
            m_over = 1'b1;
        end
        #1;
        start     = 1'b0;
        sym_valid = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic do_reset();
        start     = 1'b0;
        sym_valid = 1'b0;
        rd_en     = 1'b0;
        rst       = 1'b1;
        #1;
        m_phase  = 0;
        m_count  = 0;
        m_over   = 1'b0;
        m_rdata  = 2'b00;
        m_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sym_in  = 2'b00;
        rd_addr = '0;
        do_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sym_count !== 0
            || overrun !== 1'b0 || rd_valid !== 1'b0
            || rd_data !== 2'b00) begin
            errors++;
            $display("FAIL reset busy=%b done=%b cnt=%0d ovr=%b rv=%b rd=%b want 0s",
                     busy, done, sym_count, overrun, rd_valid, rd_data);
        end
    endtask

    task automatic test_full_capture();
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b1 || sym_count !== 0) begin
            errors++;
            $display("FAIL arm busy=%b cnt=%0d want 1/0", busy, sym_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, 2'(i % 4), 0, 0);
            if (i < DEPTH - 1) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || sym_count !== 11'(i + 1)) begin
                    errors++;
                    $display("FAIL capture i=%0d busy=%b done=%b cnt=%0d want 1/0/%0d",
                             i, busy, done, sym_count, i + 1);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sym_count !== 11'(DEPTH)) begin
            errors++;
            $display("FAIL full done=%b busy=%b cnt=%0d want 1/0/1024",
                     done, busy, sym_count);
        end
    endtask

    task automatic test_back_to_back();
        int addrs [4];
        addrs = '{0, 1, 2, 1023};
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1, AW'(addrs[k]));
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 2'(k)) begin
                errors++;
                $display("FAIL b2b addr=%0d rv=%b rd=%b want 1/%0d",
                         addrs[k], rd_valid, rd_data, k);
            end
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 2'd3) begin
            errors++;
            $display("FAIL b2b_idle rv=%b rd=%b want 0/3", rd_valid, rd_data);
        end
    endtask

    task automatic test_overrun();
        for (int k = 0; k < 3; k++) cyc(0, 1, 2'($urandom), 0, 0);
        checks++;
        if (overrun !== 1'b1 || sym_count !== 11'(DEPTH) || done !== 1'b1) begin
            errors++;
            $display("FAIL overrun ovr=%b cnt=%0d done=%b want 1/1024/1",
                     overrun, sym_count, done);
        end
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 2'b00) begin
            errors++;
            $display("FAIL overrun_mem0 rv=%b rd=%b want 1/00", rd_valid, rd_data);
        end
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1 || sym_count !== 0) begin
            errors++;
            $display("FAIL restart ovr=%b busy=%b cnt=%0d want 0/1/0",
                     overrun, busy, sym_count);
        end
    endtask

    task automatic test_start_wins();
        cyc(1, 1, 2'b11, 0, 0);
        checks++;
        if (sym_count !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_wins cnt=%0d busy=%b want 0/1", sym_count, busy);
        end
        cyc(0, 1, 2'b01, 0, 0);
        checks++;
        if (sym_count !== 1) begin
            errors++;
            $display("FAIL one_sym cnt=%0d want 1", sym_count);
        end
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 1, 2'b00, 0, 0);
        checks++;
        if (done !== 1'b1 || sym_count !== 11'(DEPTH)) begin
            errors++;
            $display("FAIL refill done=%b cnt=%0d want 1/1024", done, sym_count);
        end
        // read with a simultaneous restart must still complete
        cyc(1, 0, 0, 1, 0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 2'b01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_start rv=%b rd=%b busy=%b want 1/01/1",
                     rd_valid, rd_data, busy);
        end
    endtask

    task automatic test_read_blocked();
        cyc(0, 0, 0, 1, 5);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 2'b01) begin
            errors++;
            $display("FAIL rd_capture rv=%b rd=%b want 0/01", rd_valid, rd_data);
        end
        do_reset();
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle rv=%b rd=%b busy=%b want 0/00/0",
                     rd_valid, rd_data, busy);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) cyc(0, 1, 2'($urandom), 0, 0);
        checks++;
        if (sym_count !== 500) begin
            errors++;
            $display("FAIL pre_rst cnt=%0d want 500", sym_count);
        end
        do_reset();
        checks++;
        if (sym_count !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst cnt=%0d busy=%b done=%b want 0/0/0",
                     sym_count, busy, done);
        end
        for (int i = 0; i < 5; i++) cyc(0, 1, 2'($urandom), 0, 0);
        checks++;
        if (sym_count !== 0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL no_start cnt=%0d busy=%b ovr=%b want 0/0/0",
                     sym_count, busy, overrun);
        end
    endtask

    task automatic test_random();
        logic s;
        logic v;
        logic r;
        for (int n = 0; n < 9000; n++) begin
            if (m_phase == 0) s = ($urandom_range(0, 3) == 0);
            else if (m_phase == 2) s = ($urandom_range(0, 150) == 0);
            else s = ($urandom_range(0, 2500) == 0);
            v = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 1) == 1);
            cyc(s, v, 2'($urandom), r, AW'($urandom));
            checks++;
            if (busy !== (m_phase == 1) || done !== (m_phase == 2)
                || sym_count !== 11'(m_count) || overrun !== m_over
                || rd_valid !== m_rvalid || rd_data !== m_rdata) begin
                errors++;
                $display("FAIL random n=%0d got b%b d%b c%0d o%b v%b r%b want b%b d%b c%0d o%b v%b r%b",
                         n, busy, done, sym_count, overrun, rd_valid, rd_data,
                         m_phase == 1, m_phase == 2, m_count, m_over,
                         m_rvalid, m_rdata);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        sym_valid = 1'b0;
        sym_in    = 2'b00;
        rd_en     = 1'b0;
        rd_addr   = '0;
        test_reset();
        test_full_capture();
        test_back_to_back();
        test_overrun();
        test_start_wins();
        test_read_blocked();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
